tx_msg_queue: RTL and testbench

TX_MSG_QUEUE -- requirements
Module: tx_msg_queue

---
 rtl/tx_msg_queue.sv | 172 +++++++++++++++++
 tb/tb_tx_msg_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_msg_queue.sv
// Byte FIFO feeding the LDPC encoder / UART TX handshake.
// Bytes are queued on wr_en, popped one at a time into m, held stable for
// LOAD_TICKS baud ticks, then announced with a one-baud-period tx_start.
// The frame completes on a rising edge of tx_done or, failing that, on a
// baud-tick timeout. Overflow and timeout are reported as sticky flags.
module tx_msg_queue #(
    parameter int DEPTH         = 8,
    parameter int LOAD_TICKS    = 2,
    parameter int TIMEOUT_TICKS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_tick,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     tx_done,
    input  logic                     err_clr,
    output logic [7:0]               m,
    output logic                     tx_start,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     sent,
    output logic                     ovf_err,
    output logic                     tmo_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int TMAX = (TIMEOUT_TICKS > LOAD_TICKS) ? TIMEOUT_TICKS : LOAD_TICKS;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_TICKS - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_TICKS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] tick_cnt;
    logic          done_q;

    logic pop;
    logic wr_acc;
    logic ovf_set;
    logic done_rise;
    logic tmo_hit;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign busy  = (state != S_IDLE);

    // The head leaves the FIFO on the same edge a write lands, so a write
    // while full is still accepted when the FSM is popping.
    assign pop       = (state == S_IDLE) && !empty;
    assign wr_acc    = wr_en && (!full || pop);
    assign ovf_set   = wr_en && full && !pop;
    assign done_rise = tx_done && !done_q;
    assign tmo_hit   = (state == S_WAIT) && !done_rise && baud_tick && (tick_cnt == TMO_LAST);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Registered copy of tx_done so only a genuine 0->1 transition counts.
    always_ff @(posedge clk) begin
        if (!rst) done_q <= 1'b0;
        else      done_q <= tx_done;
    end

    // Frame sequencer: pop -> hold m -> tx_start for one baud period -> wait -> gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            m        <= 8'h00;
            tx_start <= 1'b0;
            tick_cnt <= '0;
            sent     <= 1'b0;
        end else begin
            sent <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        m        <= mem[rd_ptr];
                        tick_cnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (baud_tick) begin
                        if (tick_cnt == LOAD_LAST) begin
                            tick_cnt <= '0;
                            tx_start <= 1'b1;
                            state    <= S_START;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        tx_start <= 1'b0;
                        tick_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_rise) begin
                        sent     <= 1'b1;
                        tick_cnt <= '0;
                        state    <= S_GAP;
                    end else if (baud_tick) begin
                        if (tick_cnt == TMO_LAST) begin
                            tick_cnt <= '0;
                            state    <= S_GAP;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (baud_tick)
                        state <= S_IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a set event on the same edge beats err_clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            tmo_err <= 1'b0;
        end else begin
            if (ovf_set)      ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;
            if (tmo_hit)      tmo_err <= 1'b1;
            else if (err_clr) tmo_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_msg_queue.sv
// Bench for tx_msg_queue: a directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a queue-based model.
module tb_tx_msg_queue;

    localparam int DEPTH         = 8;
    localparam int LOAD_TICKS    = 2;
    localparam int TIMEOUT_TICKS = 24;
    localparam int LW            = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          baud_tick = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_done = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    m;
    logic          tx_start, full, empty, busy, sent, ovf_err, tmo_err;
    logic [LW-1:0] level;

    tx_msg_queue #(.DEPTH(DEPTH), .LOAD_TICKS(LOAD_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en), .wr_data(wr_data),
        .tx_done(tx_done), .err_clr(err_clr), .m(m), .tx_start(tx_start), .full(full),
        .empty(empty), .level(level), .busy(busy), .sent(sent), .ovf_err(ovf_err),
        .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_LOAD, P_START, P_WAIT, P_GAP} phase_t;
    logic [7:0] q[$];
    phase_t     ph = P_IDLE;
    int         ticks = 0;
    logic [7:0] e_m = 8'h00;
    bit         e_txs = 0, e_sent = 0, e_ovf = 0, e_tmo = 0, d_prev = 0;

    function automatic void model_step(input bit r, input bit w, input logic [7:0] d,
                                       input bit t, input bit dn, input bit c);
        bit pop, was_full, rise, ovf_set, tmo_set;
        if (!r) begin
            q.delete(); ph = P_IDLE; ticks = 0; e_m = 8'h00;
            e_txs = 0; e_sent = 0; e_ovf = 0; e_tmo = 0; d_prev = 0;
            return;
        end
        pop      = (ph == P_IDLE) && (q.size() != 0);
        was_full = (q.size() == DEPTH);
        rise     = dn && !d_prev;
        ovf_set  = w && was_full && !pop;
        tmo_set  = 0;
        e_sent   = 0;
        case (ph)
            P_IDLE:  if (pop) begin e_m = q.pop_front(); ph = P_LOAD; ticks = 0; end
            P_LOAD:  if (t) begin
                         ticks++;
                         if (ticks == LOAD_TICKS) begin ph = P_START; e_txs = 1; end
                     end
            P_START: if (t) begin ph = P_WAIT; e_txs = 0; ticks = 0; end
            P_WAIT:  if (rise) begin e_sent = 1; ph = P_GAP; end
                     else if (t) begin
                         ticks++;
                         if (ticks == TIMEOUT_TICKS) begin tmo_set = 1; ph = P_GAP; end
                     end
            P_GAP:   if (t) ph = P_IDLE;
            default: ph = P_IDLE;
        endcase
        if (w && (!was_full || pop)) q.push_back(d);
        e_ovf  = ovf_set ? 1'b1 : (c ? 1'b0 : e_ovf);
        e_tmo  = tmo_set ? 1'b1 : (c ? 1'b0 : e_tmo);
        d_prev = dn;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("level",    32'(level),    32'(q.size()));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("m",        32'(m),        32'(e_m));
        chk("tx_start", 32'(tx_start), 32'(e_txs));
        chk("busy",     32'(busy),     32'(ph != P_IDLE));
        chk("sent",     32'(sent),     32'(e_sent));
        chk("ovf_err",  32'(ovf_err),  32'(e_ovf));
        chk("tmo_err",  32'(tmo_err),  32'(e_tmo));
    endtask

    // One clock: drive inputs, clock, advance the model, compare after the edge.
    task automatic cyc(input bit r, input bit w, input logic [7:0] d,
                       input bit t, input bit dn, input bit c);
        rst = r; wr_en = w; wr_data = d; baud_tick = t; tx_done = dn; err_clr = c;
        @(posedge clk);
        model_step(r, w, d, t, dn, c);
        #1;
        compare_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         r, w, t, dn;
        logic [7:0] d;
        int         lvl;
        logic [7:0] em;
        bit         txs, bsy, snt;
    } vec_t;

    vec_t vt[12];
    int   sent_cnt;
    logic [7:0] lb[3];

    initial begin
        // single byte 8'hA5 through a complete frame
        vt[0]  = '{0,0,0,0,8'h00, 0,8'h00,0,0,0};  // reset state
        vt[1]  = '{1,1,0,0,8'hA5, 1,8'h00,0,0,0};  // queued
        vt[2]  = '{1,0,0,0,8'h00, 0,8'hA5,0,1,0};  // popped into m
        vt[3]  = '{1,0,1,0,8'h00, 0,8'hA5,0,1,0};  // 1st tick
        vt[4]  = '{1,0,0,0,8'h00, 0,8'hA5,0,1,0};
        vt[5]  = '{1,0,1,0,8'h00, 0,8'hA5,1,1,0};  // 2nd tick: tx_start
        vt[6]  = '{1,0,0,0,8'h00, 0,8'hA5,1,1,0};
        vt[7]  = '{1,0,1,0,8'h00, 0,8'hA5,0,1,0};  // one baud period later
        vt[8]  = '{1,0,0,1,8'h00, 0,8'hA5,0,1,1};  // done rises: sent
        vt[9]  = '{1,0,0,1,8'h00, 0,8'hA5,0,1,0};  // single pulse
        vt[10] = '{1,0,1,1,8'h00, 0,8'hA5,0,0,0};  // gap tick -> idle
        vt[11] = '{1,0,0,0,8'h00, 0,8'hA5,0,0,0};  // m held
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].r, vt[i].w, vt[i].d, vt[i].t, vt[i].dn, 1'b0);
            chk($sformatf("vec%0d.level", i), 32'(level), 32'(vt[i].lvl));
            chk($sformatf("vec%0d.m", i), 32'(m), 32'(vt[i].em));
            chk($sformatf("vec%0d.tx_start", i), 32'(tx_start), 32'(vt[i].txs));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].bsy));
            chk($sformatf("vec%0d.sent", i), 32'(sent), 32'(vt[i].snt));
        end

        // fill to full, overflow, clear priority, write+pop while full
        cyc(0,0,0,0,0,0);
        for (int i = 0; i < 10; i++) begin
            cyc(1,1,8'(8'h10 + i),0,0,0);
            if (i == 8) begin
                chk("fill.level8", 32'(level), 32'd8);
                chk("fill.full",   32'(full), 32'd1);
                chk("fill.no_ovf", 32'(ovf_err), 32'd0);
            end
        end
        chk("ovf.set",   32'(ovf_err), 32'd1);
        chk("ovf.level", 32'(level), 32'd8);
        chk("ovf.m",     32'(m), 32'h10);
        cyc(1,0,0,0,0,1);
        chk("ovf.clr", 32'(ovf_err), 32'd0);
        cyc(1,1,8'hEE,0,0,1);
        chk("ovf.set_wins", 32'(ovf_err), 32'd1);
        cyc(1,0,0,0,0,1);
        cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0);
        cyc(1,0,0,0,1,0);
        chk("full.sent", 32'(sent), 32'd1);
        cyc(1,0,0,1,1,0);
        cyc(1,1,8'hAA,0,0,0);
        chk("fullpop.level", 32'(level), 32'd8);
        chk("fullpop.no_ovf", 32'(ovf_err), 32'd0);
        chk("fullpop.m", 32'(m), 32'h11);

        // reset while waiting for done with three bytes queued
        cyc(0,0,0,0,0,0);
        for (int i = 0; i < 4; i++) cyc(1,1,8'(8'hC0 + i),0,0,0);
        cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0);
        chk("rstw.level3", 32'(level), 32'd3);
        chk("rstw.busy",   32'(busy), 32'd1);
        cyc(0,0,0,0,0,0);
        chk("rstw.level", 32'(level), 32'd0);
        chk("rstw.txs",   32'(tx_start), 32'd0);
        chk("rstw.busy0", 32'(busy), 32'd0);
        chk("rstw.m",     32'(m), 32'h00);

        // timeout: no tx_done
        cyc(1,1,8'h55,0,0,0);
        cyc(1,1,8'h66,0,0,0);
        cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0);
        chk("tmo.txs1", 32'(tx_start), 32'd1);
        cyc(1,0,0,1,0,0);
        chk("tmo.txs0", 32'(tx_start), 32'd0);
        for (int i = 1; i < TIMEOUT_TICKS; i++) begin
            cyc(1,0,0,1,0,0);
            chk($sformatf("tmo.early%0d", i), 32'(tmo_err), 32'd0);
        end
        cyc(1,0,0,1,0,0);
        chk("tmo.set",  32'(tmo_err), 32'd1);
        chk("tmo.sent", 32'(sent), 32'd0);
        cyc(1,0,0,1,0,0);
        chk("tmo.idle", 32'(busy), 32'd0);
        cyc(1,0,0,0,0,0);
        chk("tmo.next_m", 32'(m), 32'h66);
        cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0);
        cyc(1,0,0,0,1,0);
        chk("tmo.next_sent", 32'(sent), 32'd1);
        cyc(1,0,0,1,0,1);
        chk("tmo.clr", 32'(tmo_err), 32'd0);

        // stale tx_done held high into the wait phase
        cyc(0,0,0,0,1,0);
        cyc(1,1,8'h77,0,1,0);
        cyc(1,0,0,0,1,0);
        cyc(1,0,0,1,1,0); cyc(1,0,0,1,1,0); cyc(1,0,0,1,1,0);
        for (int i = 0; i < 3; i++) begin
            cyc(1,0,0,0,1,0);
            chk($sformatf("stale.nosent%0d", i), 32'(sent), 32'd0);
        end
        cyc(1,0,0,0,0,0);
        cyc(1,0,0,0,1,0);
        chk("stale.sent", 32'(sent), 32'd1);

        // three frames in order
        lb[0] = 8'h3C; lb[1] = 8'hFF; lb[2] = 8'h00;
        sent_cnt = 0;
        cyc(0,0,0,0,0,0);
        for (int i = 0; i < 3; i++) cyc(1,1,lb[i],0,0,0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("seq.m%0d", k), 32'(m), 32'(lb[k]));
            cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0); cyc(1,0,0,1,0,0);
            cyc(1,0,0,0,1,0);
            sent_cnt += int'(sent);
            cyc(1,0,0,1,0,0);
            cyc(1,0,0,0,0,0);
        end
        chk("seq.sent_count", 32'(sent_cnt), 32'd3);

        // randomized run against the model
        begin
            bit dn = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 9) == 0) dn = ~dn;
                cyc(($urandom_range(0, 299) != 0),
                    ($urandom_range(0, 1) == 1),
                    8'($urandom),
                    ($urandom_range(0, 2) == 0),
                    dn,
                    ($urandom_range(0, 32) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
